dsp_post_adder_accum: RTL

- Downstream stage of the DSP48A1 slice. Consumes the 36-bit multiplier product (M) and the 48-bit operands C, D:A:B and PCIN.
- Performs the X/Z-multiplexed post-add/subtract and accumulates into the 48-bit P register.
- Drives P, PCOUT, CARRYOUT/CARRYOUTF and a sticky overflow flag.
- Internal pipeline registers (M, C, OPMODE, CARRYIN, P, CARRYOUT) are individually enabled and individually bypassable by parameter.

---
 rtl/dsp_post_adder_accum.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/dsp_post_adder_accum.sv
// dsp_post_adder_accum
//
// Purpose:
//   Post-adder / accumulator stage of a DSP48A1-style slice. An X mux picks
//   zero, sign-extended M, P or D:A:B. A Z mux picks zero, PCIN, P or C. The
//   stage then forms Z + (X + CIN) or Z - (X + CIN) in 49 bits and loads the
//   48-bit result into the P register. Selecting P on either mux gives the
//   accumulate path. Each pipeline register (M, C, OPMODE, CARRYIN, P,
//   CARRYOUT) has its own clock enable and can be removed by parameter.
//
// Optional feature:
//   DSP_POST_SAT_EN - when defined, a signed overflow saturates the result to
//   the largest positive or most negative 48-bit value and forces carryout to
//   0. When undefined, the result wraps modulo 2^48.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset for all state
//   ce_m       enable for the M register and the valid_in capture
//   ce_c       enable for the C register
//   ce_opmode  enable for the opmode/op_sub register
//   ce_cin     enable for the carryin register
//   ce_p       enable for the P, CARRYOUT and valid_out registers
//   m_in       36-bit signed multiplier product
//   dab_in     48-bit D:A:B concatenation
//   c_in       48-bit C operand
//   pcin       48-bit cascade input
//   opmode     [1:0] X select, [3:2] Z select
//   op_sub     0: Z+(X+CIN), 1: Z-(X+CIN)
//   carryin    carry/borrow input
//   valid_in   operand qualifier, travels with M
//   clr_ovf    synchronous clear of the sticky overflow flag
//   p_out      post-adder result
//   pcout      cascade copy of p_out
//   carryout   bit 48 of the post-adder sum
//   carryoutf  fabric copy of carryout
//   ovf        sticky signed-overflow flag
//   valid_out  p_out qualifier

module dsp_post_adder_accum #(
    parameter int MREG        = 1,
    parameter int CREG        = 1,
    parameter int OPMODEREG   = 1,
    parameter int CARRYINREG  = 1,
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_m,
    input  logic        ce_c,
    input  logic        ce_opmode,
    input  logic        ce_cin,
    input  logic        ce_p,
    input  logic [35:0] m_in,
    input  logic [47:0] dab_in,
    input  logic [47:0] c_in,
    input  logic [47:0] pcin,
    input  logic [3:0]  opmode,
    input  logic        op_sub,
    input  logic        carryin,
    input  logic        valid_in,
    input  logic        clr_ovf,
    output logic [47:0] p_out,
    output logic [47:0] pcout,
    output logic        carryout,
    output logic        carryoutf,
    output logic        ovf,
    output logic        valid_out
);

    logic [35:0] m_s;
    logic        valid_m;
    logic [47:0] c_s;
    logic [3:0]  opmode_s;
    logic        op_sub_s;
    logic        cin_s;
    logic [47:0] p_fb;
    logic [47:0] x_mux;
    logic [47:0] z_mux;
    logic [48:0] sum;
    logic        ovf_det;
    logic [47:0] p_next;
    logic        carry_next;

    // M stage; valid_in rides along with the product.
    if (MREG != 0) begin : g_mreg
        logic [35:0] m_q;
        logic        v_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_q <= '0;
                v_q <= 1'b0;
            end else if (ce_m) begin
                m_q <= m_in;
                v_q <= valid_in;
            end
        end
        assign m_s     = m_q;
        assign valid_m = v_q;
    end else begin : g_mbyp
        assign m_s     = m_in;
        assign valid_m = valid_in;
    end

    if (CREG != 0) begin : g_creg
        logic [47:0] c_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)      c_q <= '0;
            else if (ce_c) c_q <= c_in;
        end
        assign c_s = c_q;
    end else begin : g_cbyp
        assign c_s = c_in;
    end

    if (OPMODEREG != 0) begin : g_opreg
        logic [3:0] op_q;
        logic       sub_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                op_q  <= '0;
                sub_q <= 1'b0;
            end else if (ce_opmode) begin
                op_q  <= opmode;
                sub_q <= op_sub;
            end
        end
        assign opmode_s = op_q;
        assign op_sub_s = sub_q;
    end else begin : g_opbyp
        assign opmode_s = opmode;
        assign op_sub_s = op_sub;
    end

    if (CARRYINREG != 0) begin : g_cinreg
        logic cin_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)        cin_q <= 1'b0;
            else if (ce_cin) cin_q <= carryin;
        end
        assign cin_s = cin_q;
    end else begin : g_cinbyp
        assign cin_s = carryin;
    end

    // X and Z operand selection.
    always_comb begin
        x_mux = '0;
        case (opmode_s[1:0])
            2'd0:    x_mux = '0;
            2'd1:    x_mux = {{12{m_s[35]}}, m_s};
            2'd2:    x_mux = p_fb;
            default: x_mux = dab_in;
        endcase
        z_mux = '0;
        case (opmode_s[3:2])
            2'd0:    z_mux = '0;
            2'd1:    z_mux = pcin;
            2'd2:    z_mux = p_fb;
            default: z_mux = c_s;
        endcase
    end

    // 49-bit post-add; bit 48 is carry (add) or borrow (subtract). Overflow
    // is judged against the Z sign, which is also the overflow direction.
    always_comb begin
        if (op_sub_s) begin
            sum     = {1'b0, z_mux} - {1'b0, x_mux} - {48'd0, cin_s};
            ovf_det = (z_mux[47] != x_mux[47]) && (sum[47] != z_mux[47]);
        end else begin
            sum     = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin_s};
            ovf_det = (z_mux[47] == x_mux[47]) && (sum[47] != z_mux[47]);
        end
`ifdef DSP_POST_SAT_EN
        if (ovf_det) begin
            p_next     = z_mux[47] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
            carry_next = 1'b0;
        end else begin
            p_next     = sum[47:0];
            carry_next = sum[48];
        end
`else
        p_next     = sum[47:0];
        carry_next = sum[48];
`endif
    end

    // P stage; valid_out follows the same enable as P.
    if (PREG != 0) begin : g_preg
        logic [47:0] p_q;
        logic        vp_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                p_q  <= '0;
                vp_q <= 1'b0;
            end else if (ce_p) begin
                p_q  <= p_next;
                vp_q <= valid_m;
            end
        end
        assign p_fb      = p_q;
        assign p_out     = p_q;
        assign valid_out = vp_q;
    end else begin : g_pbyp
        // With no P register the feedback path has no meaning; tie it off.
        assign p_fb      = '0;
        assign p_out     = p_next;
        assign valid_out = valid_m;
    end

    if (CARRYOUTREG != 0) begin : g_coreg
        logic co_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)      co_q <= 1'b0;
            else if (ce_p) co_q <= carry_next;
        end
        assign carryout = co_q;
    end else begin : g_cobyp
        assign carryout = carry_next;
    end

    // Sticky overflow; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                ovf <= 1'b0;
        else if (ce_p && ovf_det) ovf <= 1'b1;
        else if (clr_ovf)        ovf <= 1'b0;
    end

    assign pcout     = p_out;
    assign carryoutf = carryout;

endmodule
